bcd_tick_counter: RTL
=====================

Name: bcd_tick_counter

Overview:
- Single-digit decade (0-9) counter with run/stop and clear buttons and up/down direction.
- Sits directly upstream of the BCD-to-7-segment decoder; `count_o` drives the decoder's 4-bit count input.
- Internal prescaler converts the fast system clock into count ticks.
- Buttons are debounced internally; `carry_o` allows cascading further digits.

Parameters:
- PRESCALE, 1000000, clk cycles per count tick (>=2).
- DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a button level change (>=2).
- PRESCALE_W, $clog2(PRESCALE), prescaler width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  global enable; low freezes every register.
- btn_run_i  input  1  raw run/stop button, active-high.
- btn_clr_i  input  1  raw clear button, active-high.
- dir_i  input  1  1 = count up, 0 = count down; level input, not debounced.
- count_o  output  4  current digit, always 0..9.
- carry_o  output  1  one-cycle pulse on wrap (9->0 up, 0->9 down).
- running_o  output  1  1 while the FSM is in RUN.

Behaviour:
- **Reset** (rst_n low, async), all outputs low:
  - count_o=0, carry_o=0, running_o=0.
  - FSM=STOP, prescaler=0.
  - Debounced levels=0, debounce counters=0.
- **ena=0:** all registers hold, no events are generated, and carry_o is forced to 0.
- **Debounce** (per button):
  - Counter counts edges on which the raw level differs from the debounced level; it resets to 0 whenever they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the raw level at that edge.
  - A press event is a 0->1 change of the debounced level. It is a one-cycle pulse, acted on at the next edge.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
- **FSM states:** STOP, RUN.
  - A run press toggles STOP<->RUN.
  - running_o is registered and equals (state==RUN).
- **Prescaler:**
  - Increments only in RUN.
  - At PRESCALE-1 it asserts the internal tick and returns to 0.
  - In STOP it holds its value; it does not clear.
- **On tick**, dir_i is sampled that cycle:
  - Up: count+1; 9->0 wraps and carry_o=1 for the next cycle.
  - Down: count-1; 0->9 wraps and carry_o=1.
  - Otherwise carry_o=0.
- **Clear press:**
  - count=0, prescaler=0, carry_o=0; FSM state is unchanged.
  - Clear beats a tick in the same cycle; no carry is produced.
- **Simultaneous run and clear press:** both take effect (toggle state, clear count).
- **Out-of-range values:** count_o never leaves 0..9. Any illegal internal value (e.g. after an SEU) is forced to 0 on the next edge without a carry.
- **Reset mid-operation:** immediate return to reset values; a pending debounce is discarded.

Optional Feature:
- Macro BCD_TICK_COUNTER_SYNC_EN.
- Defined:
  - btn_run_i, btn_clr_i and dir_i each pass through a 2-flop synchronizer (reset to 0) before the debounce/tick logic.
  - Press latency grows by 2 cycles; dir_i sampling is delayed by 2 cycles.
- Undefined: raw inputs feed the logic directly. The integrator must guarantee they are synchronous to clk.

Decomposition:
- Shared package `bcd_tick_pkg`:
  - State typedef (STOP=1'b0, RUN=1'b1).
  - Constant BCD_MAX=4'd9.
  - Constant BCD_W=4.
- One natural sub-module, `btn_debounce`:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst_n, ena, raw_i, level_o, press_o.
  - Instantiated twice.

Test Plan (PRESCALE=4, DEBOUNCE_CYCLES=3, macro undefined):
1. Reset, then hold btn_run_i=1 for 3 edges with dir_i=1:
   - running_o=1 on the edge after acceptance.
   - count_o goes 1,2,3 every 4 cycles.
2. Run up from 8 -> 9 -> 0:
   - carry_o=1 for exactly one cycle, coincident with count_o=0.
   - Then dir_i=0: count_o goes 9 with carry_o pulse, then 8.
3. btn_run_i pulse of 2 cycles (shorter than DEBOUNCE_CYCLES):
   - No state change; running_o stays 0 and count stays 0.
4. In RUN, assert a clear press timed to coincide with a tick:
   - count_o=0, carry_o=0, running_o stays 1.
   - Next tick after 4 more cycles gives count_o=1.
5. Drop ena=0 for 10 cycles mid-count:
   - count_o, the prescaler phase and debounce progress all hold.
   - Counting resumes with the same phase.
6. Assert rst_n=0 asynchronously between edges while count_o=7 in RUN:
   - count_o=0, running_o=0, carry_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bcd_tick_pkg.sv
// Shared types and constants for the BCD tick counter and its debouncer.
package bcd_tick_pkg;

  typedef enum logic {
    StStop = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  function automatic logic bcd_valid(logic [BCD_W-1:0] value);
    return value <= BCD_MAX;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: accepts a new level after DEBOUNCE_CYCLES consecutive differing samples
// and emits a one-cycle press pulse on an accepted 0->1 change.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (raw_i != level_q) begin
      // The edge that brings the count to DEBOUNCE_CYCLES is the accepting edge.
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = raw_i;
        cnt_d   = '0;
        press_d = raw_i;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else if (ena) begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q & ena;

endmodule

// File: rtl/bcd_tick_counter.sv
// Single-digit decade counter with run/stop, clear and up/down control.
// Define BCD_TICK_COUNTER_SYNC_EN to add 2-flop synchronizers on the raw inputs.
module bcd_tick_counter
  import bcd_tick_pkg::*;
#(
  parameter int unsigned PRESCALE        = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             btn_run_i,
  input  logic             btn_clr_i,
  input  logic             dir_i,
  output logic [BCD_W-1:0] count_o,
  output logic             carry_o,
  output logic             running_o
);

  localparam int unsigned PRESCALE_W = $clog2(PRESCALE);
  localparam logic [PRESCALE_W-1:0] PreLast = PRESCALE_W'(PRESCALE - 1);

  logic run_s, clr_s, dir_s;

`ifdef BCD_TICK_COUNTER_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else if (ena) begin
      sync1_q <= {btn_run_i, btn_clr_i, dir_i};
      sync2_q <= sync1_q;
    end
  end

  assign {run_s, clr_s, dir_s} = sync2_q;
`else
  assign run_s = btn_run_i;
  assign clr_s = btn_clr_i;
  assign dir_s = dir_i;
`endif

  logic run_press, clr_press;
  logic unused_run_level, unused_clr_level;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_run_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .raw_i  (run_s),
    .level_o(unused_run_level),
    .press_o(run_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clr_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .raw_i  (clr_s),
    .level_o(unused_clr_level),
    .press_o(clr_press)
  );

  state_e                state_q, state_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [BCD_W-1:0]      count_q, count_d;
  logic                  carry_q, carry_d;
  logic                  tick;

  assign tick = (state_q == StRun) && (pre_q == PreLast);

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    count_d = count_q;
    carry_d = 1'b0;

    if (run_press) begin
      state_d = (state_q == StRun) ? StStop : StRun;
    end

    if (state_q == StRun) begin
      // Values above PreLast are unreachable except by upset; recover silently.
      pre_d = (pre_q >= PreLast) ? '0 : pre_q + PRESCALE_W'(1);
    end

    if (clr_press) begin
      count_d = '0;
      pre_d   = '0;
    end else if (!bcd_valid(count_q)) begin
      count_d = '0;
    end else if (tick) begin
      if (dir_s) begin
        if (count_q == BCD_MAX) begin
          count_d = '0;
          carry_d = 1'b1;
        end else begin
          count_d = count_q + BCD_W'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = BCD_MAX;
          carry_d = 1'b1;
        end else begin
          count_d = count_q - BCD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StStop;
      pre_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count_o   = count_q;
  assign carry_o   = carry_q & ena;
  assign running_o = (state_q == StRun);

endmodule
